// File: rtl/fwd_track_unit.sv
// Forwarding / load-use interlock controller for the integer pipeline.
// Tracks in-flight writer tags and registers per-source bypass selects.
module fwd_track_unit #(
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int SW      = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dec_valid,
  input  logic                  dec_wen,
  input  logic [AW-1:0]         dec_rd,
  input  logic                  dec_load,
  input  logic [NUM_SRC*AW-1:0] dec_rs,
  input  logic [NUM_SRC-1:0]    dec_rs_used,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  stall,
  output logic [NUM_SRC*SW-1:0] fwd_sel,
  output logic                  x_valid
);

  // Index 0 is entry 1 (X), index DEPTH-1 is the retire buffer.
  logic [DEPTH-1:0]         tag_v;
  logic [DEPTH-1:0][AW-1:0] tag_rd;
  // Only a load sitting in X can cause an interlock, so the load
  // flag is kept for entry 1 alone.
  logic                     ld_x;

  logic [NUM_SRC*SW-1:0] sel_d;
  logic                  ld_hit;
  logic                  issue;

  // Tag compare: newest (lowest) matching entry wins per source.
  always_comb begin
    sel_d  = '0;
    ld_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (dec_rs_used[i] &&
            (dec_rs[i*AW +: AW] != '0) &&
            tag_v[k] &&
            (tag_rd[k] == dec_rs[i*AW +: AW])) begin
          sel_d[i*SW +: SW] = SW'(k + 1);
          if ((k == 0) && ld_x) ld_hit = 1'b1;
        end
      end
    end
  end

  assign stall = dec_valid & ~flush & ld_hit;
  assign issue = ~stall & ~hold & ~flush;

  // Tag pipeline and registered X-stage selects.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_v   <= '0;
      tag_rd  <= '0;
      ld_x    <= 1'b0;
      fwd_sel <= '0;
      x_valid <= 1'b0;
    end else begin
      // Flush forces a bubble into X even while frozen.
      if (flush || !hold) begin
        tag_v[0]  <= dec_valid & dec_wen & (dec_rd != '0) & issue;
        tag_rd[0] <= dec_rd;
        ld_x      <= dec_load;
        fwd_sel   <= issue ? sel_d : '0;
        x_valid   <= dec_valid & issue;
      end
      if (!hold) begin
        for (int k = 1; k < DEPTH; k++) begin
          tag_v[k]  <= tag_v[k-1];
          tag_rd[k] <= tag_rd[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_fwd_track_unit.sv
// Directed bench for fwd_track_unit with an output scoreboard.
// Hand-derived expectations are queued at drive time, checked after the edge.
module tb_fwd_track_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       dec_valid, dec_wen, dec_load;
  logic [4:0] dec_rd;
  logic [9:0] dec_rs;
  logic [1:0] dec_rs_used;
  logic       hold, flush;
  logic       stall;
  logic [3:0] fwd_sel;
  logic       x_valid;

  typedef struct packed {
    logic [3:0] sel;
    logic       xv;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_no = 0;

  fwd_track_unit dut (
    .clock       (clock),
    .reset       (reset),
    .dec_valid   (dec_valid),
    .dec_wen     (dec_wen),
    .dec_rd      (dec_rd),
    .dec_load    (dec_load),
    .dec_rs      (dec_rs),
    .dec_rs_used (dec_rs_used),
    .hold        (hold),
    .flush       (flush),
    .stall       (stall),
    .fwd_sel     (fwd_sel),
    .x_valid     (x_valid)
  );

  always #5 clock = ~clock;

  task automatic step(
    input logic       rst, hld, fl,
    input logic       v, wen, ld,
    input logic [4:0] rd, rs0, rs1,
    input logic [1:0] used,
    input logic       es,
    input logic [1:0] e0, e1,
    input logic       exv
  );
    exp_t e;
    exp_t got;
    @(negedge clock);
    step_no++;
    reset       = rst;
    hold        = hld;
    flush       = fl;
    dec_valid   = v;
    dec_wen     = wen;
    dec_load    = ld;
    dec_rd      = rd;
    dec_rs      = {rs1, rs0};
    dec_rs_used = used;
    #1;
    n_tests++;
    assert (stall === es) else begin
      n_fail++;
      $error("FAIL stall step %0d: got %b want %b", step_no, stall, es);
    end
    q.push_back('{sel: {e1, e0}, xv: exv});
    @(posedge clock);
    #1;
    e = q.pop_front();
    got = '{sel: fwd_sel, xv: x_valid};
    n_tests++;
    assert (got.sel === e.sel) else begin
      n_fail++;
      $error("FAIL fwd_sel step %0d: got %h want %h",
             step_no, got.sel, e.sel);
    end
    n_tests++;
    assert (got.xv === e.xv) else begin
      n_fail++;
      $error("FAIL x_valid step %0d: got %b want %b",
             step_no, got.xv, e.xv);
    end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    dec_valid = 1'b0; dec_wen = 1'b0; dec_load = 1'b0;
    dec_rd = '0; dec_rs = '0; dec_rs_used = '0;
    //   rst h f  v w l  rd  rs0 rs1 used  st s0 s1 xv
    step(1, 0,0, 0,0,0, 0,  0,  0,  2'b00, 0, 0, 0, 0);
    // back-to-back ALU chain
    step(0, 0,0, 1,1,0, 3,  1,  2,  2'b11, 0, 0, 0, 1);
    step(0, 0,0, 1,1,0, 5,  3,  4,  2'b11, 0, 1, 0, 1);
    // distance 2, 3, 4
    step(0, 0,0, 1,1,0, 8,  3,  0,  2'b11, 0, 2, 0, 1);
    step(0, 0,0, 1,1,0, 9,  3,  5,  2'b11, 0, 3, 2, 1);
    step(0, 0,0, 1,1,0, 10, 3,  3,  2'b11, 0, 0, 0, 1);
    // load-use: one stall cycle then sel 2 on both
    step(0, 0,0, 1,1,1, 2,  0,  1,  2'b10, 0, 0, 0, 1);
    step(0, 0,0, 1,1,0, 6,  2,  2,  2'b11, 1, 0, 0, 0);
    step(0, 0,0, 1,1,0, 6,  2,  2,  2'b11, 0, 2, 2, 1);
    // priority: two writers of r7
    step(0, 0,0, 1,1,0, 7,  0,  0,  2'b00, 0, 0, 0, 1);
    step(0, 0,0, 1,1,0, 7,  0,  0,  2'b00, 0, 0, 0, 1);
    step(0, 0,0, 1,0,0, 0,  7,  6,  2'b11, 0, 1, 3, 1);
    // load to r0, unused matching source
    step(0, 0,0, 1,1,1, 0,  7,  0,  2'b00, 0, 0, 0, 1);
    step(0, 0,0, 1,0,0, 0,  0,  0,  2'b11, 0, 0, 0, 1);
    // flush over a load-use condition
    step(0, 0,0, 1,1,1, 4,  0,  0,  2'b00, 0, 0, 0, 1);
    step(0, 0,1, 1,1,0, 11, 4,  0,  2'b01, 0, 0, 0, 0);
    step(0, 0,0, 1,1,0, 12, 4,  0,  2'b01, 0, 2, 0, 1);
    // hold for three cycles mid-chain
    step(0, 0,0, 1,1,0, 13, 12, 4,  2'b11, 0, 1, 3, 1);
    step(0, 1,0, 1,1,0, 14, 13, 12, 2'b11, 0, 1, 3, 1);
    step(0, 1,0, 1,1,0, 14, 13, 12, 2'b11, 0, 1, 3, 1);
    step(0, 1,0, 1,1,0, 14, 13, 12, 2'b11, 0, 1, 3, 1);
    step(0, 0,0, 1,1,0, 14, 13, 12, 2'b11, 0, 1, 2, 1);
    // stall still visible while held
    step(0, 0,0, 1,1,1, 15, 14, 0,  2'b01, 0, 1, 0, 1);
    step(0, 1,0, 1,1,0, 16, 15, 14, 2'b11, 1, 1, 0, 1);
    step(0, 0,0, 1,1,0, 16, 15, 14, 2'b11, 1, 0, 0, 0);
    step(0, 0,0, 1,1,0, 16, 15, 14, 2'b11, 0, 2, 3, 1);
    // reset during a load-use stall
    step(0, 0,0, 1,1,1, 17, 0,  0,  2'b00, 0, 0, 0, 1);
    step(1, 0,0, 1,1,0, 18, 17, 0,  2'b01, 1, 0, 0, 0);
    step(0, 0,0, 1,1,0, 18, 17, 0,  2'b01, 0, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
